// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap/redirect/stall priority and a small
// circular return-address stack that predicts return targets.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_target,
    input  logic                         trap,
    input  logic [XLEN-1:0]              trap_vector,
    input  logic                         call,
    input  logic                         ret,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_plus4,
    output logic                         misaligned_err,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];

    assign pc_plus4       = pc_q + XLEN'(4);
    assign pc             = pc_q;
    assign misaligned_err = err_q;
    assign ras_count      = count_q;

    // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
    assign top_inc = top_q + PTR_W'(1);
    assign top_dec = top_q - PTR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        err_d   = 1'b0;
        top_d   = top_q;
        count_d = count_q;
        ras_d   = ras_q;
        if (trap) begin
            pc_d = trap_vector & ~XLEN'(3);
        end else if (redirect) begin
            if (redirect_target[1:0] == 2'b00) pc_d = redirect_target;
            else                                err_d = 1'b1;
        end else if (!stall) begin
            pc_d = pc_plus4;
            if (ret && count_q != '0) pc_d = ras_q[top_q];
            if (call && ret) begin
                // Return followed by a call: the popped slot is reused in place.
                ras_d[top_q] = pc_plus4;
                if (count_q == '0) count_d = CNT_W'(1);
            end else if (call) begin
                ras_d[top_inc] = pc_plus4;
                top_d          = top_inc;
                if (count_q != CNT_W'(RAS_DEPTH)) count_d = count_q + CNT_W'(1);
            end else if (ret && count_q != '0) begin
                top_d   = top_dec;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            err_q   <= 1'b0;
            top_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            err_q   <= err_d;
            top_q   <= top_d;
            count_q <= count_d;
            ras_q   <= ras_d;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (XLEN=32, RESET_VECTOR=0, RAS_DEPTH=4).
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset, stall, redirect, trap, call, ret;
    logic [31:0] redirect_target, trap_vector;
    logic [31:0] pc, pc_plus4;
    logic        misaligned_err;
    logic [2:0]  ras_count;
    int checks = 0;
    int errors = 0;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .trap(trap), .trap_vector(trap_vector),
        .call(call), .ret(ret), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned_err(misaligned_err), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect = 0; trap = 0; call = 0; ret = 0;
        redirect_target = '0; trap_vector = '0;
    endtask

    task automatic test_reset();
        reset = 0; idle();
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ras_count); end
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", misaligned_err); end
        reset = 1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", pc); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL run_pc got %h want %h", pc, 32'(4 * i)); end
            checks++; if (pc_plus4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL run_pc4 got %h want %h", pc_plus4, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_redirect();
        redirect = 1; redirect_target = 32'h100;
        tick();
        redirect = 0; stall = 1;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h want 100", pc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h100) begin errors++; $display("FAIL stall_pc got %h want 100", pc); end
        end
        stall = 0;
        tick();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL release_pc got %h want 104", pc); end
        redirect = 1; redirect_target = 32'h102;
        tick();
        redirect = 0; stall = 1;
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL misredir_pc got %h want 104", pc); end
        checks++; if (misaligned_err !== 1'b1) begin errors++; $display("FAIL misredir_err got %b want 1", misaligned_err); end
        tick();
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", misaligned_err); end
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL mis_stall_pc got %h want 104", pc); end
        tick();
        stall = 0;
        tick();
        checks++; if (pc !== 32'h108) begin errors++; $display("FAIL mis_release_pc got %h want 108", pc); end
    endtask

    task automatic test_priority();
        trap = 1; trap_vector = 32'h203; redirect = 1; redirect_target = 32'h102;
        stall = 1; call = 1;
        tick();
        idle();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL trap_pc got %h want 200", pc); end
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL trap_err got %b want 0", misaligned_err); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL trap_nopush got %0d want 0", ras_count); end
    endtask

    task automatic test_ras();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h28};
        redirect = 1; redirect_target = 32'h10;
        tick();
        for (int i = 1; i <= 5; i++) begin
            idle(); call = 1;
            tick();
            checks++; if (ras_count !== 3'((i > 4) ? 4 : i)) begin errors++; $display("FAIL call_cnt got %0d want %0d", ras_count, (i > 4) ? 4 : i); end
            idle();
            if (i < 5) begin
                redirect = 1; redirect_target = 32'(16 * (i + 1));
                tick();
            end
        end
        checks++; if (pc !== 32'h54) begin errors++; $display("FAIL after_calls_pc got %h want 54", pc); end
        for (int i = 0; i < 5; i++) begin
            idle(); ret = 1;
            tick();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL ret_pc got %h want %h", pc, exp_pc[i]); end
            checks++; if (ras_count !== 3'((i >= 3) ? 0 : 3 - i)) begin errors++; $display("FAIL ret_cnt got %0d want %0d", ras_count, (i >= 3) ? 0 : 3 - i); end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        redirect = 1; redirect_target = 32'h40;
        tick();
        idle(); call = 1;
        tick();
        idle(); redirect = 1; redirect_target = 32'h80;
        tick();
        idle(); call = 1; ret = 1;
        tick();
        idle();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL callret_pc got %h want 44", pc); end
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL callret_cnt got %0d want 1", ras_count); end
        ret = 1;
        tick();
        idle();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL newtop_pc got %h want 84", pc); end
        stall = 1; call = 1;
        tick();
        idle();
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL stall_call_cnt got %0d want 0", ras_count); end
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL stall_call_pc got %h want 84", pc); end
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1; redirect_target = 32'hFFFF_FFFC;
        tick();
        idle();
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", pc_plus4); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
        call = 1;
        tick(); tick(); tick();
        checks++; if (ras_count !== 3'd3) begin errors++; $display("FAIL pre_reset_cnt got %0d want 3", ras_count); end
        reset = 0;
        tick();
        reset = 1; call = 0; ret = 1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midreset_pc got %h want 0", pc); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL midreset_cnt got %0d want 0", ras_count); end
        tick();
        idle();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_ret got %h want 4", pc); end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_priority();
        test_ras();
        test_back_to_back();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
